// File: rtl/pakout_buf_pkg.sv
// Shared sizes and handshake FSM encodings for the pakout buffer.
package pakout_buf_pkg;

  localparam int unsigned NS_ON           = 1;
  localparam int unsigned NS_OFF          = 0;
  localparam int unsigned NS_ADDRESS_SIZE = 4;
  localparam int unsigned NS_DATA_SIZE    = 8;
  localparam int unsigned NS_PACKET_SIZE  = 2 * NS_ADDRESS_SIZE + NS_DATA_SIZE;

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_ACK  = 1'b1
  } in_state_t;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_REQ  = 1'b1
  } out_state_t;

endpackage

// File: rtl/pakout_fifo.sv
// Synchronous FIFO with wrapping pointers and a registered occupancy count one bit wider than the pointers.
module pakout_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_c,
  output logic [$clog2(DEPTH):0]   o_cnt,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = i_push & ~o_full;
  assign pop_ok   = i_pop & ~o_empty;
  assign o_head_c = mem[rd_ptr];

  always_comb begin
    cnt_nxt = o_cnt;
    case ({push_ok, pop_ok})
      2'b10:   cnt_nxt = o_cnt + CW'(1);
      2'b01:   cnt_nxt = o_cnt - CW'(1);
      default: cnt_nxt = o_cnt;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_cnt   <= '0;
      o_full  <= 1'b0;
      o_empty <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      o_cnt   <= cnt_nxt;
      o_full  <= (cnt_nxt == CW'(DEPTH));
      o_empty <= (cnt_nxt == '0);
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_data;
  end

endmodule

// File: rtl/pakout_buf.sv
// Packs req/ack messages into {dst,src,dat} packets, buffers them and replays them on a req/ack packet port.
// Define NS_PAKOUT_RANGE_CHK_EN to drop (but still acknowledge) messages with an out-of-range destination.
module pakout_buf
  import pakout_buf_pkg::*;
#(
  parameter int unsigned ASZ      = NS_ADDRESS_SIZE,
  parameter int unsigned DSZ      = NS_DATA_SIZE,
  parameter int unsigned PSZ      = NS_PACKET_SIZE,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MIN_ADDR = 1,
  parameter int unsigned MAX_ADDR = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [ASZ-1:0]         i_src,
  input  logic [ASZ-1:0]         i_dst,
  input  logic [DSZ-1:0]         i_dat,
  input  logic                   i_req,
  output logic                   o_ack,
  output logic [PSZ-1:0]         o_pak,
  output logic                   o_req,
  input  logic                   i_ack,
  output logic [$clog2(DEPTH):0] o_cnt,
  output logic                   o_full,
  output logic                   o_err
);

  if (PSZ != 2 * ASZ + DSZ) begin : g_bad_psz
    $error("pakout_buf: PSZ must equal 2*ASZ+DSZ");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pakout_buf: DEPTH must be a power of two and at least 2");
  end
  if (MIN_ADDR > MAX_ADDR) begin : g_bad_range
    $error("pakout_buf: MIN_ADDR must not exceed MAX_ADDR");
  end

  in_state_t      in_state, in_state_nxt;
  out_state_t     out_state, out_state_nxt;
  logic           accept_c, in_range_c, push_c, pop_c;
  logic           ack_nxt, req_nxt;
  logic [PSZ-1:0] pak_nxt, head_c;
  logic           fifo_full, fifo_empty;

  pakout_fifo #(
    .WIDTH (PSZ),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_push   (push_c),
    .i_data   ({i_dst, i_src, i_dat}),
    .i_pop    (pop_c),
    .o_head_c (head_c),
    .o_cnt    (o_cnt),
    .o_full   (fifo_full),
    .o_empty  (fifo_empty)
  );

  assign o_full = fifo_full;

`ifdef NS_PAKOUT_RANGE_CHK_EN
  assign in_range_c = (i_dst >= ASZ'(MIN_ADDR)) && (i_dst <= ASZ'(MAX_ADDR));

  always_ff @(posedge i_clk) begin
    if (i_rst)                        o_err <= 1'b0;
    else if (accept_c && !in_range_c) o_err <= 1'b1;
  end
`else
  assign in_range_c = 1'b1;
  assign o_err      = 1'b0;
`endif

  // Input handshake: a full FIFO holds the request off until space frees up.
  always_ff @(posedge i_clk) begin
    if (i_rst) in_state <= IN_IDLE;
    else       in_state <= in_state_nxt;
  end

  always_comb begin
    in_state_nxt = in_state;
    case (in_state)
      IN_IDLE: if (i_req && !fifo_full) in_state_nxt = IN_ACK;
      IN_ACK:  if (!i_req)              in_state_nxt = IN_IDLE;
    endcase
  end

  always_comb begin
    accept_c = 1'b0;
    ack_nxt  = 1'b0;
    case (in_state)
      IN_IDLE: begin
        accept_c = i_req && !fifo_full;
        ack_nxt  = accept_c;
      end
      IN_ACK: ack_nxt = i_req;
    endcase
    push_c = accept_c && in_range_c;
  end

  // Output handshake: pop into o_pak only once the consumer has released i_ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) out_state <= OUT_IDLE;
    else       out_state <= out_state_nxt;
  end

  always_comb begin
    out_state_nxt = out_state;
    case (out_state)
      OUT_IDLE: if (!fifo_empty && !i_ack) out_state_nxt = OUT_REQ;
      OUT_REQ:  if (i_ack)                 out_state_nxt = OUT_IDLE;
    endcase
  end

  always_comb begin
    pop_c   = 1'b0;
    req_nxt = 1'b0;
    pak_nxt = o_pak;
    case (out_state)
      OUT_IDLE: begin
        pop_c   = !fifo_empty && !i_ack;
        req_nxt = pop_c;
        if (pop_c) pak_nxt = head_c;
      end
      OUT_REQ: req_nxt = !i_ack;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ack <= 1'b0;
      o_req <= 1'b0;
      o_pak <= '0;
    end else begin
      o_ack <= ack_nxt;
      o_req <= req_nxt;
      o_pak <= pak_nxt;
    end
  end

endmodule

// File: tb/tb_pakout_buf.sv
// Bench for pakout_buf: per-cycle vector table, directed multi-cycle sequences and random traffic vs a queue model.
`timescale 1ns/1ps
module tb_pakout_buf;

  localparam int unsigned ASZ = 4, DSZ = 8, PSZ = 16, DEPTH = 4, CW = 3;
  localparam int unsigned MIN_A = 1, MAX_A = 3;
  localparam int NORMAL = 0, HOLD_HI = 1, HOLD_LO = 2;
`ifdef NS_PAKOUT_RANGE_CHK_EN
  localparam int   EXP_RANGE_DELIV = 1;
  localparam logic EXP_RANGE_ERR   = 1'b1;
`else
  localparam int   EXP_RANGE_DELIV = 3;
  localparam logic EXP_RANGE_ERR   = 1'b0;
`endif

  logic           i_clk = 1'b0;
  logic           i_rst, i_req, i_ack;
  logic [ASZ-1:0] i_src, i_dst;
  logic [DSZ-1:0] i_dat;
  logic           o_ack, o_req, o_full, o_err;
  logic [PSZ-1:0] o_pak;
  logic [CW-1:0]  o_cnt;

  pakout_buf #(
    .ASZ(ASZ), .DSZ(DSZ), .PSZ(PSZ), .DEPTH(DEPTH), .MIN_ADDR(MIN_A), .MAX_ADDR(MAX_A)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_src(i_src), .i_dst(i_dst), .i_dat(i_dat),
    .i_req(i_req), .o_ack(o_ack), .o_pak(o_pak), .o_req(o_req), .i_ack(i_ack),
    .o_cnt(o_cnt), .o_full(o_full), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
  } msg_t;

  typedef struct {
    logic           rst, req, ack;
    logic [ASZ-1:0] src, dst;
    logic [DSZ-1:0] dat;
    logic           e_ack, e_req, e_full;
    logic [PSZ-1:0] e_pak;
    logic [CW-1:0]  e_cnt;
  } vec_t;

  int             checks = 0, errors = 0;
  int             n_acc = 0, n_deliv = 0, max_cnt = 0;
  int             cons_mode = NORMAL, prod_pct = 100, cons_pct = 100;
  logic           seen = 1'b0, m_err = 1'b0;
  msg_t           cur;
  msg_t           tx_q[$];
  logic [PSZ-1:0] exp_q[$];
  vec_t           vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic msg_t mk(input int s, input int d, input int v);
    msg_t m;
    m.src = ASZ'(s);
    m.dst = ASZ'(d);
    m.dat = DSZ'(v);
    return m;
  endfunction

  // Reference: every acknowledged message is queued unless range checking rejects it.
  function automatic void model_accept(input msg_t m);
    n_acc++;
`ifdef NS_PAKOUT_RANGE_CHK_EN
    if (int'(m.dst) < int'(MIN_A) || int'(m.dst) > int'(MAX_A)) begin
      m_err = 1'b1;
      return;
    end
`endif
    exp_q.push_back({m.dst, m.src, m.dat});
  endfunction

  task automatic agent_step();
    @(negedge i_clk);
    if (i_req && o_ack) begin
      model_accept(cur);
      i_req = 1'b0;
    end else if (!i_req && !o_ack && tx_q.size() > 0 && int'($urandom_range(99)) < prod_pct) begin
      cur   = tx_q.pop_front();
      i_src = cur.src;
      i_dst = cur.dst;
      i_dat = cur.dat;
      i_req = 1'b1;
    end
    if (!o_req) seen = 1'b0;
    else if (!seen) begin
      seen = 1'b1;
      n_deliv++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pak_extra: got 0x%0h want no packet", o_pak);
      end else check("pak_order", 32'(o_pak), 32'(exp_q.pop_front()));
    end
    case (cons_mode)
      HOLD_HI: i_ack = 1'b1;
      HOLD_LO: i_ack = 1'b0;
      default: begin
        if (o_req && seen && !i_ack && int'($urandom_range(99)) < cons_pct) i_ack = 1'b1;
        else if (!o_req && i_ack && int'($urandom_range(99)) < cons_pct) i_ack = 1'b0;
      end
    endcase
    check("cnt", 32'(o_cnt), 32'(exp_q.size()));
    check("full", 32'(o_full), 32'(exp_q.size() == DEPTH));
    check("err", 32'(o_err), 32'(m_err));
    if (int'(o_cnt) > max_cnt) max_cnt = int'(o_cnt);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) agent_step();
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      agent_step();
      if (tx_q.size() == 0 && !i_req && !o_ack && exp_q.size() == 0 && !o_req && !i_ack) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d queued want 0", exp_q.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0;
    i_rst = 1'b1; i_req = 1'b0; i_ack = 1'b0; i_src = '0; i_dst = '0; i_dat = '0;

    // rst req ack src dst dat | e_ack e_req e_full e_pak e_cnt
    vt[0] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0};
    vt[1] = '{1'b1, 1'b1, 1'b0, 4'd2, 4'd1, 8'd7, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 8'd7, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd1};
    vt[3] = '{1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 8'd7, 1'b0, 1'b1, 1'b0, 16'h1207, 3'd0};
    vt[4] = '{1'b0, 1'b0, 1'b1, 4'd2, 4'd1, 8'd7, 1'b0, 1'b0, 1'b0, 16'h1207, 3'd0};
    vt[5] = '{1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 8'd7, 1'b0, 1'b0, 1'b0, 16'h1207, 3'd0};
    for (int i = 0; i < 6; i++) begin
      i_rst = vt[i].rst; i_req = vt[i].req; i_ack = vt[i].ack;
      i_src = vt[i].src; i_dst = vt[i].dst; i_dat = vt[i].dat;
      @(negedge i_clk);
      check($sformatf("v%0d_ack", i), 32'(o_ack), 32'(vt[i].e_ack));
      check($sformatf("v%0d_req", i), 32'(o_req), 32'(vt[i].e_req));
      check($sformatf("v%0d_pak", i), 32'(o_pak), 32'(vt[i].e_pak));
      check($sformatf("v%0d_cnt", i), 32'(o_cnt), 32'(vt[i].e_cnt));
      check($sformatf("v%0d_full", i), 32'(o_full), 32'(vt[i].e_full));
      check($sformatf("v%0d_err", i), 32'(o_err), 32'(0));
    end

    // Fill with the consumer holding i_ack high: four accepted, fifth stalls.
    a0 = n_acc; d0 = n_deliv;
    cons_mode = HOLD_HI;
    for (int i = 0; i < 5; i++) tx_q.push_back(mk(1, 2, i));
    run(20);
    check("fill_acks", 32'(n_acc - a0), 32'(4));
    check("fill_full", 32'(o_full), 32'(1));
    check("fill_cnt", 32'(o_cnt), 32'(4));
    check("fill_ack_low", 32'(o_ack), 32'(0));
    cons_mode = NORMAL;
    drain(500);
    check("fill_deliv", 32'(n_deliv - d0), 32'(5));

    // Streaming with both sides responding immediately.
    d0 = n_deliv; max_cnt = 0;
    for (int i = 0; i < 16; i++) tx_q.push_back(mk(3, 1, i));
    drain(500);
    check("stream_deliv", 32'(n_deliv - d0), 32'(16));
    check("stream_cnt_le2", 32'(max_cnt <= 2), 32'(1));

    // Reset while a packet is outstanding and three remain buffered.
    cons_mode = HOLD_HI;
    for (int i = 0; i < 4; i++) tx_q.push_back(mk(2, 3, 8'h40 + i));
    run(20);
    cons_mode = HOLD_LO;
    run(2);
    check("rst_pre_req", 32'(o_req), 32'(1));
    check("rst_pre_cnt", 32'(o_cnt), 32'(3));
    i_rst = 1'b1; i_req = 1'b0; i_ack = 1'b0;
    @(negedge i_clk);
    check("rst_ack", 32'(o_ack), 32'(0));
    check("rst_req", 32'(o_req), 32'(0));
    check("rst_cnt", 32'(o_cnt), 32'(0));
    check("rst_pak", 32'(o_pak), 32'(0));
    check("rst_full", 32'(o_full), 32'(0));
    i_rst = 1'b0;
    exp_q.delete(); tx_q.delete(); seen = 1'b0; m_err = 1'b0;
    cons_mode = NORMAL;
    d0 = n_deliv;
    tx_q.push_back(mk(5, 2, 8'h99));
    drain(200);
    check("post_rst_deliv", 32'(n_deliv - d0), 32'(1));

    // Destination range: dst 0, 2, 4 against MIN_ADDR=1, MAX_ADDR=3.
    a0 = n_acc; d0 = n_deliv;
    tx_q.push_back(mk(1, 0, 8'hA0));
    tx_q.push_back(mk(1, 2, 8'hA1));
    tx_q.push_back(mk(1, 4, 8'hA2));
    drain(300);
    check("range_acks", 32'(n_acc - a0), 32'(3));
    check("range_deliv", 32'(n_deliv - d0), 32'(EXP_RANGE_DELIV));
    check("range_err", 32'(o_err), 32'(EXP_RANGE_ERR));

    // Random traffic with random pacing on both sides.
    prod_pct = 60; cons_pct = 50;
    for (int i = 0; i < 150; i++)
      tx_q.push_back(mk(int'($urandom_range(15)), int'($urandom_range(7)), int'($urandom_range(255))));
    drain(6000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
